// File: rtl/iob_bus_arbiter_2to1.sv
// rtl/iob_bus_arbiter_2to1.sv - two-master to one-slave IOb native bus arbiter
//
// Purpose:
//   Merges two IOb native masters (typically CPU dbus on m0, ibus on m1)
//   onto one slave port. The grant is combinational, so the request path
//   adds no latency. A small owner FIFO remembers which master issued each
//   in-flight read so that in-order read responses are routed back to the
//   right master.
//
// Ports:
//   clk_i      clock
//   arst_i     asynchronous reset, active high
//   cke_i      clock enable; low freezes every register
//   m0_req_i   master 0 request {valid, addr, wdata, wstrb}
//   m0_resp_o  master 0 response {rdata, rvalid, ready}
//   m1_req_i   master 1 request, same layout as m0
//   m1_resp_o  master 1 response, same layout as m0
//   s_req_o    merged request to the slave
//   s_resp_i   slave response {rdata, rvalid, ready}
//   err_o      sticky: slave returned rvalid with no read outstanding

module iob_bus_arbiter_2to1 #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTST  = 4,
  parameter int FIXED_PRIO = 0,
  localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W    = DATA_W + 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic [REQ_W-1:0]  m0_req_i,
  output logic [RESP_W-1:0] m0_resp_o,
  input  logic [REQ_W-1:0]  m1_req_i,
  output logic [RESP_W-1:0] m1_resp_o,
  output logic [REQ_W-1:0]  s_req_o,
  input  logic [RESP_W-1:0] s_resp_i,
  output logic              err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTST);

  // Grant encoding: 0 = m0, 1 = m1.
  logic                 gnt_q, gnt_d;
  logic                 lock_q, lock_d;
  logic                 last_q, last_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [MAX_OUTST-1:0] own_q, own_d;
  logic                 err_q, err_d;

  logic              m0_valid, m1_valid;
  logic              gnt;
  logic [REQ_W-1:0]  sel_req;
  logic              sel_valid;
  logic              sel_is_read;
  logic              s_ready, s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic              full;
  logic              stall;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              owner;

  assign m0_valid = m0_req_i[REQ_W-1];
  assign m1_valid = m1_req_i[REQ_W-1];
  assign s_ready  = s_resp_i[0];
  assign s_rvalid = s_resp_i[1];
  assign s_rdata  = s_resp_i[RESP_W-1:2];

  // A held (locked) request keeps its grant until it transfers so the
  // slave never sees the request change under it.
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = gnt_q;
    end else if (m0_valid && !m1_valid) begin
      gnt = 1'b0;
    end else if (!m0_valid && m1_valid) begin
      gnt = 1'b1;
    end else if (m0_valid && m1_valid) begin
      gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  always_comb begin
    sel_req     = gnt ? m1_req_i : m0_req_i;
    sel_valid   = sel_req[REQ_W-1];
    sel_is_read = (sel_req[STRB_W-1:0] == '0);
    full        = (count_q == FULL_CNT);
    // A full owner FIFO blocks new reads, unless a response pops a slot
    // in this very cycle.
    stall       = sel_valid && sel_is_read && full && !s_rvalid;
    xfer        = sel_valid && s_ready && !stall;
    push        = xfer && sel_is_read;
    // With an empty FIFO the only legal owner is a read pushed this cycle.
    pop         = s_rvalid && ((count_q != '0) || push);
    owner       = (count_q == '0) ? gnt : own_q[rptr_q];
  end

  assign s_req_o   = {sel_valid && !stall, sel_req[REQ_W-2:0]};
  assign m0_resp_o = {s_rdata, pop && !owner, !gnt && s_ready && !stall};
  assign m1_resp_o = {s_rdata, pop &&  owner,  gnt && s_ready && !stall};
  assign err_o     = err_q;

  always_comb begin
    gnt_d   = gnt_q;
    lock_d  = sel_valid && !xfer;
    last_d  = last_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    own_d   = own_q;
    err_d   = err_q;

    if (sel_valid && !xfer) begin
      gnt_d = gnt;
    end
    if (xfer) begin
      last_d = gnt;
    end
    if (push) begin
      own_d[wptr_q] = gnt;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (s_rvalid && !pop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      gnt_q   <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      own_q   <= '0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      own_q   <= own_d;
      err_q   <= err_d;
    end
  end

endmodule
